// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the boot-time program loader.
`default_nettype none

package prog_loader_pkg;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      ST_HDR0  = 3'd0,
      ST_HDR1  = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_RUN   = 3'd4,
      ST_ERR   = 3'd5
   } state_e;

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] wd;
   } mem_port_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader_word_packer.sv
// word_packer: collects four bytes little-endian (first byte lands in [7:0]).
`default_nettype none

module word_packer
   import prog_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        full_o
);

   logic [31:0] word_q, word_d;
   logic [1:0]  idx_q, idx_d;

   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      if (clear_i) begin
         word_d = 32'd0;
         idx_d  = 2'd0;
      end else if (shift_i) begin
         // Shift right so that after four bytes the first one sits in [7:0].
         word_d = {byte_i, word_q[31:8]};
         idx_d  = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_q <= 32'd0;
         idx_q  <= 2'd0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

   assign word_o = word_q;
   assign full_o = shift_i && (idx_q == 2'(WORD_BYTES - 1));

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed byte stream into memory, then hands the
// memory port to the core and releases its reset.
`default_nettype none

module prog_loader
   import prog_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 64
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   input  logic        reload,
   input  logic        core_MemWrite,
   input  logic [31:0] core_Adr,
   input  logic [31:0] core_WriteData,
   output logic        mem_we,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wd,
   output logic        cpu_reset,
   output logic        done,
   output logic        error,
   output logic [15:0] word_cnt
);

   state_e      state_q, state_d;
   logic [7:0]  hdr_lo_q, hdr_lo_d;
   logic [15:0] nwords_q, nwords_d;
   logic [15:0] cnt_q, cnt_d;
   logic        cpu_reset_q, done_q, error_q;

   logic        accept;
   logic [15:0] hdr_n;
   logic        pk_clear, pk_shift, pk_full;
   logic [31:0] pk_word;
   mem_port_t   ldr_port;

   assign rx_ready = !reset && ((state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                                (state_q == ST_DATA));
   assign accept   = rx_valid && rx_ready;
   assign hdr_n    = {rx_data, hdr_lo_q};

   always_comb begin
      state_d  = state_q;
      hdr_lo_d = hdr_lo_q;
      nwords_d = nwords_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_HDR0: begin
            if (accept) begin
               hdr_lo_d = rx_data;
               state_d  = ST_HDR1;
            end
         end
         ST_HDR1: begin
            if (accept) begin
               nwords_d = hdr_n;
               if (hdr_n == 16'd0) begin
                  state_d = ST_RUN;
               end else if ({16'd0, hdr_n} > 32'(MAX_WORDS)) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_DATA;
                  cnt_d   = 16'd0;
               end
            end
         end
         ST_DATA: begin
            if (pk_full) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            cnt_d   = cnt_q + 16'd1;
            state_d = (cnt_q + 16'd1 == nwords_q) ? ST_RUN : ST_DATA;
         end
         ST_RUN, ST_ERR: begin
            if (reload) begin
               state_d = ST_HDR0;
               cnt_d   = 16'd0;
            end
         end
         default: state_d = ST_HDR0;
      endcase
   end

   // Status outputs are registered from the next state so they change with it cleanly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_HDR0;
         hdr_lo_q    <= 8'd0;
         nwords_q    <= 16'd0;
         cnt_q       <= 16'd0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_lo_q    <= hdr_lo_d;
         nwords_q    <= nwords_d;
         cnt_q       <= cnt_d;
         cpu_reset_q <= (state_d != ST_RUN);
         done_q      <= (state_d == ST_RUN);
         error_q     <= (state_d == ST_ERR);
      end
   end

   assign pk_clear = (state_d == ST_DATA) && (state_q != ST_DATA);
   assign pk_shift = accept && (state_q == ST_DATA);

   word_packer u_packer (
      .clk     (clk),
      .reset   (reset),
      .clear_i (pk_clear),
      .shift_i (pk_shift),
      .byte_i  (rx_data),
      .word_o  (pk_word),
      .full_o  (pk_full)
   );

   always_comb begin
      ldr_port.we  = (state_q == ST_WRITE);
      ldr_port.adr = BASE_ADDR + {14'd0, cnt_q, 2'b00};
      ldr_port.wd  = (state_q == ST_WRITE) ? pk_word : 32'd0;
   end

   always_comb begin
      if (state_q == ST_RUN) begin
         mem_we  = core_MemWrite;
         mem_adr = core_Adr;
         mem_wd  = core_WriteData;
      end else begin
         mem_we  = ldr_port.we;
         mem_adr = ldr_port.adr;
         mem_wd  = ldr_port.wd;
      end
   end

   assign cpu_reset = cpu_reset_q;
   assign done      = done_q;
   assign error     = error_q;
   assign word_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader and memory-port owner for the multi-cycle ARM system. It holds the core in reset while it receives a byte stream, packs the bytes into 32-bit little-endian words and writes them into the unified instruction/data memory. It then hands the memory port to the core and releases the core's reset. It sits between the core's memory outputs (`MemWrite`, `Adr`, `WriteData`) and the memory's `we`/`a`/`wd` inputs.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first loaded word.
- `MAX_WORDS`, default 64: largest accepted word count.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_valid` in 1: byte available from the serial/host source.
- `rx_data` in 8: byte value.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `reload` in 1: pulse that restarts loading from RUN or ERR.
- `core_MemWrite` in 1: core write enable.
- `core_Adr` in 32: core address.
- `core_WriteData` in 32: core write data.
- `mem_we` out 1: to memory `we`.
- `mem_adr` out 32: to memory `a`.
- `mem_wd` out 32: to memory `wd`.
- `cpu_reset` out 1: drives the core's `reset`.
- `done` out 1: load complete, core running.
- `error` out 1: header word count exceeds `MAX_WORDS`.
- `word_cnt` out 16: number of words written so far.

## Operation
- Stream format:
  - Bytes 0–1 carry the word count N as a 16-bit little-endian value.
  - They are followed by 4·N bytes, each word little-endian (first byte goes to [7:0]).
- A byte is accepted when `rx_valid && rx_ready` at a rising edge. Bytes are never accepted while `reset` is high.
- States:
  - HDR0: `rx_ready`=1. On accept, latch the low count byte and go to HDR1.
  - HDR1: `rx_ready`=1. On accept, latch the high byte.
    - N=0 → RUN.
    - N>`MAX_WORDS` → ERR.
    - Otherwise → DATA with byte index 0 and word index 0.
  - DATA: `rx_ready`=1. Each accept shifts the byte into the word register. The 4th byte goes to WRITE.
  - WRITE: one cycle.
    - `rx_ready`=0, `mem_we`=1, `mem_adr`=`BASE_ADDR`+4·index, `mem_wd`=packed word.
    - Increment the index.
    - Go to RUN when index+1==N, else back to DATA.
  - RUN: `cpu_reset`=0, `done`=1, `rx_ready`=0. `reload` → HDR0.
  - ERR: `error`=1, `cpu_reset`=1, `rx_ready`=0. `reload` → HDR0.
- Memory mux:
  - In RUN, `mem_we`/`mem_adr`/`mem_wd` are combinational copies of the `core_*` inputs.
  - In all other states the loader drives them, and `mem_we`=1 only in WRITE.
- Address arithmetic is 32-bit, modulo 2^32, with no overflow detection.
- `word_cnt` counts completed WRITE cycles. It clears on reset and on entry to HDR0.

## Timing
- Reset values: state HDR0, `cpu_reset`=1, `mem_we`=0, `mem_adr`=`BASE_ADDR`, `mem_wd`=0, `done`=0, `error`=0, `word_cnt`=0. `rx_ready`=1 from the first cycle after reset deasserts.
- Write latency: the 4th byte is accepted at edge t, and WRITE (memory write) occurs in cycle t+1.
- A source holding `rx_valid` through WRITE is stalled one cycle per word. Sustained throughput is 4 bytes per 5 cycles.
- After the last WRITE, the loader enters RUN at the next edge. `cpu_reset` falls and `done` rises in that same cycle. The core's first fetch uses the same cycle's mux.
- `cpu_reset`, `done` and `error` are registered functions of state and glitch-free.
- Simultaneous events:
  - `reset` with `reload` → reset wins.
  - `reload` in HDR0/HDR1/DATA/WRITE is ignored.
  - `reload` in RUN → HDR0 at the next edge. `cpu_reset` rises that edge and any core write in that RUN cycle still completes.
- Reset mid-load: return to HDR0, discard the partial word and the count. Memory already written is not cleared.

## Structure
- Package `prog_loader_pkg` holds:
  - the state enum (HDR0, HDR1, DATA, WRITE, RUN, ERR);
  - `HDR_BYTES`=2 and `WORD_BYTES`=4;
  - the memory-port struct type (we, adr, wd).
- Sub-module `word_packer`:
  - 4×8-bit little-endian shift register with a 2-bit byte index and a `full` flag;
  - `clear` on entry to DATA.
- Top level holds the FSM, word index/count registers, address generator and output mux.

## Test plan
- Stream 02 00, 78 56 34 12, EF BE AD DE with `rx_valid` constant → writes 0x12345678@0x0 and 0xDEADBEEF@0x4 in the WRITE cycles; `cpu_reset` falls and `done`=1 the cycle after the second write; `word_cnt`=2.
- Header 00 00 → HDR1→RUN directly with no memory write; `done`=1 two cycles after the first accept.
- Header 41 00 with `MAX_WORDS`=64 → ERR, `error`=1, `cpu_reset` stays 1, `rx_ready`=0. Then `reload` → HDR0 with `error`=0.
- In RUN, drive `core_MemWrite`=1, `core_Adr`=0x20, `core_WriteData`=0xA5 → identical values on `mem_*` in the same cycle. In HDR0 the same inputs → `mem_we`=0.
- Assert `reset` after 2 of 4 data bytes, then resend the full 1-word stream 01 00 11 22 33 44 → single write 0x44332211@`BASE_ADDR`, with no stale bytes.
- Gapped `rx_valid` (random idle cycles) with `BASE_ADDR`=0x100 → words land at 0x100, 0x104, … in order; no byte is accepted during WRITE.
